// File: rtl/arf_sequencer_if.sv
// Handshake and control bundle between the instruction control unit,
// the ARF sequencer and the ARF/memory datapath.
interface arf_sequencer_if;
    logic       req_valid;
    logic [2:0] req_op;
    logic       req_ready;
    logic       done;
    logic       err;
    logic       busy;
    logic [2:0] reg_sel;
    logic [2:0] fun_sel;
    logic [1:0] out_c_sel;
    logic [1:0] out_d_sel;
    logic       i_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_ack;

    // Requester / memory side: issues ops and answers strobes.
    modport master (
        output req_valid, req_op, mem_ack,
        input  req_ready, done, err, busy, reg_sel, fun_sel,
               out_c_sel, out_d_sel, i_sel, mem_rd, mem_wr
    );

    // Sequencer side: accepts ops and drives the ARF and memory controls.
    modport slave (
        input  req_valid, req_op, mem_ack,
        output req_ready, done, err, busy, reg_sel, fun_sel,
               out_c_sel, out_d_sel, i_sel, mem_rd, mem_wr
    );
endinterface

// File: rtl/arf_sequencer.sv
// ARF sequencer: turns one high-level address operation (NOP, FETCH, PUSH,
// POP, CALL, RET, LDAR, JUMP) into per-cycle ARF controls and memory strobes.
// Memory steps wait for mem_ack and abort to ERR after ACK_TIMEOUT idle cycles.
module arf_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    arf_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_S1, ST_S2, ST_S3, ST_ERR
    } state_e;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_FETCH = 3'b001;
    localparam logic [2:0] OP_PUSH  = 3'b010;
    localparam logic [2:0] OP_POP   = 3'b011;
    localparam logic [2:0] OP_CALL  = 3'b100;
    localparam logic [2:0] OP_RET   = 3'b101;
    localparam logic [2:0] OP_LDAR  = 3'b110;
    localparam logic [2:0] OP_JUMP  = 3'b111;

    // Active-low register enables
    localparam logic [2:0] EN_NONE = 3'b111;
    localparam logic [2:0] EN_ALL  = 3'b000;
    localparam logic [2:0] EN_PC   = 3'b011;
    localparam logic [2:0] EN_AR   = 3'b101;
    localparam logic [2:0] EN_SP   = 3'b110;

    localparam logic [2:0] FN_DEC   = 3'b000;
    localparam logic [2:0] FN_INC   = 3'b001;
    localparam logic [2:0] FN_LOAD  = 3'b010;
    localparam logic [2:0] FN_CLEAR = 3'b011;

    localparam logic [1:0] SEL_PC = 2'b00;
    localparam logic [1:0] SEL_SP = 2'b11;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic       req_ready, busy, done, err;
    logic [2:0] reg_sel, fun_sel;
    logic [1:0] out_c_sel, out_d_sel;
    logic       i_sel, mem_rd, mem_wr;
    logic       last_step, mem_step;

    // State, latched op and memory wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            op_q    <= OP_NOP;
            wait_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    // Step decode from (state, op) and next-state selection
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = '0;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        reg_sel   = EN_NONE;
        fun_sel   = FN_DEC;
        out_c_sel = SEL_PC;
        out_d_sel = SEL_PC;
        i_sel     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        last_step = 1'b0;
        mem_step  = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                reg_sel = EN_ALL;
                fun_sel = FN_CLEAR;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    state_d = ST_S1;
                end
            end
            ST_ERR: begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                if (state_q == ST_S1) begin
                    unique case (op_q)
                        OP_NOP:   last_step = 1'b1;
                        OP_FETCH: begin out_d_sel = SEL_PC; mem_rd = 1'b1; end
                        OP_PUSH:  begin out_d_sel = SEL_SP; mem_wr = 1'b1; end
                        OP_POP:   begin reg_sel = EN_SP; fun_sel = FN_INC; end
                        OP_CALL:  begin out_d_sel = SEL_SP; out_c_sel = SEL_PC; mem_wr = 1'b1; end
                        OP_RET:   begin reg_sel = EN_SP; fun_sel = FN_INC; end
                        OP_LDAR:  begin reg_sel = EN_AR; fun_sel = FN_LOAD; last_step = 1'b1; end
                        OP_JUMP:  begin reg_sel = EN_PC; fun_sel = FN_LOAD; last_step = 1'b1; end
                        default:  last_step = 1'b1;
                    endcase
                end else if (state_q == ST_S2) begin
                    unique case (op_q)
                        OP_FETCH: begin reg_sel = EN_PC; fun_sel = FN_INC; last_step = 1'b1; end
                        OP_PUSH:  begin reg_sel = EN_SP; fun_sel = FN_DEC; last_step = 1'b1; end
                        OP_POP:   begin out_d_sel = SEL_SP; mem_rd = 1'b1; last_step = 1'b1; end
                        OP_CALL:  begin reg_sel = EN_SP; fun_sel = FN_DEC; end
                        OP_RET:   begin out_d_sel = SEL_SP; mem_rd = 1'b1; end
                        default:  last_step = 1'b1;
                    endcase
                end else begin
                    unique case (op_q)
                        OP_CALL: begin reg_sel = EN_PC; fun_sel = FN_LOAD; i_sel = 1'b0; last_step = 1'b1; end
                        OP_RET:  begin reg_sel = EN_PC; fun_sel = FN_LOAD; i_sel = 1'b1; last_step = 1'b1; end
                        default: last_step = 1'b1;
                    endcase
                end

                mem_step = mem_rd | mem_wr;
                // A final memory step (POP) only completes once the ack arrives,
                // so a timed-out POP never reports Done.
                done = last_step & (~mem_step | bus.mem_ack);

                if (mem_step && !bus.mem_ack) begin
                    if (wait_q == CNT_W'(ACK_TIMEOUT)) state_d = ST_ERR;
                    else                               wait_d  = wait_q + CNT_W'(1);
                end else if (last_step) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = (state_q == ST_S1) ? ST_S2 : ST_S3;
                end
            end
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err;
    assign bus.reg_sel   = reg_sel;
    assign bus.fun_sel   = fun_sel;
    assign bus.out_c_sel = out_c_sel;
    assign bus.out_d_sel = out_d_sel;
    assign bus.i_sel     = i_sel;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
endmodule
